// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Groups the upstream word handshake and the downstream serial stream of
//   bit_serializer into one bundle.
//   data_in    : parallel word from upstream
//   data_valid : data_in is valid
//   data_ready : serializer can take a word this cycle
//   ser_out    : serial bit stream toward the pattern detector
//   ser_valid  : ser_out carries a payload bit
//   word_done  : last bit of a word is on ser_out this cycle
//   busy       : a word is shifting or held
//   master drives words in and observes the stream; slave is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, ser_out, ser_valid, word_done, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, ser_out, ser_valid, word_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial converter feeding the serial pattern detector.
//   Takes WIDTH-bit words over valid/ready and emits one bit per clock with
//   no gap between back-to-back words. A one-word hold register lets the next
//   word be accepted while the current one is still shifting.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : bit_serializer_if.slave (word handshake in, serial stream out)
//   Parameters:
//     WIDTH     : word width, >= 2
//     MSB_FIRST : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
//     IDLE_BIT  : ser_out level while ser_valid is low
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             rdy_en;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             free;
  logic             accept;

  // Control state: async reset so the stream goes idle without waiting for clk.
  // rdy_en keeps data_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_full <= hold_full_nxt;
      rdy_en    <= 1'b1;
    end
  end

  // Data registers carry no reset; their contents are ignored until a load.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
    hold  <= hold_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hold_full_nxt = hold_full;
    shreg_nxt     = shreg;
    hold_nxt      = hold;

    // The shifter can take a new word when idle or while its last bit is out,
    // which is what makes back-to-back words gapless.
    free   = (state == IDLE) || (cnt == LAST);
    accept = bus.data_valid && bus.data_ready;

    if (free) begin
      if (hold_full) begin
        // data_ready is low here, so no accept can collide with this load.
        shreg_nxt     = hold;
        hold_full_nxt = 1'b0;
        cnt_nxt       = '0;
        state_nxt     = SHIFT;
      end else if (accept) begin
        shreg_nxt = bus.data_in;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end else begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    end else begin
      cnt_nxt = cnt + 1'b1;
      if (MSB_FIRST) begin
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
      end
      if (accept) begin
        hold_nxt      = bus.data_in;
        hold_full_nxt = 1'b1;
      end
    end
  end

  assign bus.ser_valid  = (state == SHIFT);
  assign bus.ser_out    = bus.ser_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  assign bus.word_done  = bus.ser_valid && (cnt == LAST);
  assign bus.busy       = bus.ser_valid || hold_full;
  assign bus.data_ready = rdy_en && !hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Drives two serializers (MSB-first with IDLE_BIT=0, LSB-first with
//   IDLE_BIT=1) with identical word traffic. Every accepted word pushes its
//   expected bit sequence into a per-lane queue; each valid output bit pops
//   and compares value and word_done.
module tb_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] data_in;
  logic data_valid;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) ifm ();
  bit_serializer_if #(.WIDTH(W)) ifl ();

  assign ifm.data_in    = data_in;
  assign ifm.data_valid = data_valid;
  assign ifl.data_in    = data_in;
  assign ifl.data_valid = data_valid;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .bus(ifm));
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .reset(reset), .bus(ifl));

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] q_m[$];  // {last, bit}
  logic [1:0] q_l[$];
  int acc_cnt = 0;
  int run = 0;
  int max_run = 0;
  bit ready_armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Accept monitor: pre-edge values decide whether this edge takes a word.
  always @(posedge clk) begin
    if (!reset) begin
      if (data_valid && ifm.data_ready) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back({(i == W-1) ? 1'b1 : 1'b0, data_in[W-1-i]});
          q_l.push_back({(i == W-1) ? 1'b1 : 1'b0, data_in[i]});
        end
        acc_cnt++;
      end
      ready_armed = 1'b1;
    end
  end

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      chk("m_busy",  ifm.busy, (q_m.size() != 0));
      chk("m_ready", ifm.data_ready, (ready_armed && q_m.size() <= W));
      chk("l_ready", ifl.data_ready, (ready_armed && q_l.size() <= W));
      if (ifm.ser_valid) begin
        if (q_m.size() == 0) chk("m_extra_bit", 1, 0);
        else begin
          e = q_m.pop_front();
          chk("m_bit",  ifm.ser_out,   e[0]);
          chk("m_done", ifm.word_done, e[1]);
        end
        run++;
        if (run > max_run) max_run = run;
      end else begin
        chk("m_idle_out",  ifm.ser_out,   0);
        chk("m_idle_done", ifm.word_done, 0);
        run = 0;
      end
      if (ifl.ser_valid) begin
        if (q_l.size() == 0) chk("l_extra_bit", 1, 0);
        else begin
          e = q_l.pop_front();
          chk("l_bit",  ifl.ser_out,   e[0]);
          chk("l_done", ifl.word_done, e[1]);
        end
      end else begin
        chk("l_idle_out",  ifl.ser_out,   1);
        chk("l_idle_done", ifl.word_done, 0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [W-1:0] w);
    int start;
    int k;
    start = acc_cnt;
    k = 0;
    data_in = w;
    data_valid = 1'b1;
    while (acc_cnt == start && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    data_valid = 1'b0;
    @(negedge clk);
    while ((ifm.busy || ifl.busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", (ifm.busy || ifl.busy), 0);
    chk("queues_empty", q_m.size() + q_l.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    ready_armed = 1'b0;
    #1;
    q_m.delete();
    q_l.delete();
    chk("rst_m_valid", ifm.ser_valid, 0);
    chk("rst_m_out",   ifm.ser_out,   0);
    chk("rst_l_out",   ifl.ser_out,   1);
    chk("rst_busy",    ifm.busy || ifl.busy, 0);
    chk("rst_ready",   ifm.data_ready, 0);
    chk("rst_done",    ifm.word_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_low_after_release", ifm.data_ready, 0);
    @(negedge clk);
    run = 0;
    max_run = 0;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    #1;
    chk("init_valid", ifm.ser_valid, 0);
    chk("init_ready", ifm.data_ready, 0);
    do_reset();

    // Single word, both bit orders
    send(8'hB0);
    data_valid = 1'b0;
    chk("first_bit_valid", ifm.ser_valid, 1);
    drain();
    chk("single_run", max_run, 8);

    // Back-to-back with data_valid held: hold register fills
    max_run = 0;
    send(8'hB0);
    send(8'h0B);
    data_valid = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      chk("b2b_ready_low", ifm.data_ready, 0);
      @(negedge clk);
    end
    chk("b2b_ready_back", ifm.data_ready, 1);
    drain();
    chk("b2b_run", max_run, 16);

    // Word 0D: LSB lane yields 1,0,1,1,0,0,0,0
    max_run = 0;
    send(8'h0D);
    drain();

    // Backpressure: three words presented continuously
    max_run = 0;
    send(8'hA5);
    send(8'h3C);
    send(8'hF1);
    drain();
    chk("bp_run", max_run, 24);

    // Reset mid-word with a word held, then a clean word
    send(8'hA5);
    send(8'h3C);
    data_valid = 1'b0;
    do_reset();
    send(8'h96);
    drain();
    chk("post_reset_run", max_run, 8);

    // New word arrives exactly when word_done is high
    max_run = 0;
    send(8'hC3);
    data_valid = 1'b0;
    k = 0;
    while (!ifm.word_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("word_done_seen", ifm.word_done, 1);
    send(8'h5A);
    data_valid = 1'b0;
    chk("direct_load_valid", ifm.ser_valid, 1);
    chk("direct_load_ready", ifm.data_ready, 1);
    drain();
    chk("direct_run", max_run, 16);

    // Random words with random gaps
    max_run = 0;
    for (int i = 0; i < 12; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        data_valid = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
